// File: rtl/cacheline_burst_adaptor.sv
`default_nettype none
// ============================================================================
// cacheline_burst_adaptor
// Converts one cache-line read/write into a BURST_LEN-beat memory burst.
// Optional macro ADAPTOR_STATS_EN adds completed read/write counters.
// Revision: 1.0
// ============================================================================
module cacheline_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
`ifdef ADAPTOR_STATS_EN
  ,
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o
`endif
);

  localparam int BURST_LEN = LINE_W / BURST_W;
  localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFF_W     = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0]  C_LAST     = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] C_OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]                  r_cnt;
  logic [BURST_LEN-1:0][BURST_W-1:0] r_buf;
  logic [BURST_LEN-1:0][BURST_W-1:0] w_assembled;
  logic [LINE_W-1:0]                 r_line;
  logic [ADDR_W-1:0]                 r_addr;
  logic [ADDR_W-1:0]                 w_aligned;
  logic                              w_final;

  assign w_aligned = address_i & ~C_OFF_MASK;
  assign w_final   = resp_i && (r_cnt == C_LAST);

  always_comb begin
    w_assembled        = r_buf;
    w_assembled[r_cnt] = burst_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    read_o       = 1'b0;
    write_o      = 1'b0;
    resp_o       = 1'b0;
    burst_o      = '0;
    case (r_state)
      ST_IDLE: begin
        // Dirty writeback must reach memory before the refill read.
        if (write_i)     w_state_next = ST_WRITE;
        else if (read_i) w_state_next = ST_READ;
      end
      ST_READ: begin
        read_o = 1'b1;
        if (w_final) w_state_next = ST_DONE;
      end
      ST_WRITE: begin
        write_o = 1'b1;
        burst_o = r_buf[r_cnt];
        if (w_final) w_state_next = ST_DONE;
      end
      default: begin
        resp_o       = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_buf  <= '0;
      r_line <= '0;
      r_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (write_i) begin
            r_buf  <= line_i;
            r_addr <= w_aligned;
          end else if (read_i) begin
            r_buf  <= '0;
            r_addr <= w_aligned;
          end
        end
        ST_READ: begin
          if (resp_i) begin
            r_buf <= w_assembled;
            if (w_final) begin
              r_cnt  <= '0;
              r_line <= w_assembled;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (resp_i) begin
            if (w_final) r_cnt <= '0;
            else         r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // line_o is a read-only copy so writebacks never disturb the last fill.
  assign line_o    = r_line;
  assign address_o = r_addr;

`ifdef ADAPTOR_STATS_EN
  logic        r_was_read;
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_was_read <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == ST_IDLE && (write_i || read_i)) r_was_read <= !write_i;
      if (r_state == ST_DONE) begin
        if (r_was_read) r_rd_count <= r_rd_count + 32'd1;
        else            r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign rd_count_o = r_rd_count;
  assign wr_count_o = r_wr_count;
`endif

endmodule
`default_nettype wire

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
Sits directly downstream of the direct-mapped cache datapath, between its 256-bit pmem_* line interface and the 64-bit burst physical-memory bus. Converts one 256-bit line read or write into a 4-beat burst. Buffers the line and presents a single-cycle completion pulse back to the cache controller. One transaction in flight at a time.

Parameters:
LINE_W, 256, cache line width in bits
BURST_W, 64, physical-memory beat width in bits; LINE_W must be a multiple of BURST_W
BURST_LEN, LINE_W/BURST_W (4), beats per line; derived, not overridden
ADDR_W, 32, address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
line_i  input  LINE_W  line to write back (cache pmem_wdata)
line_o  output  LINE_W  assembled line from memory (cache pmem_rdata)
address_i  input  ADDR_W  line address from cache (pmem_address)
read_i  input  1  line read request, level, held until resp_o
write_i  input  1  line write request, level, held until resp_o
resp_o  output  1  transaction complete, 1-cycle pulse
burst_i  input  BURST_W  read beat data from memory
burst_o  output  BURST_W  write beat data to memory
address_o  output  ADDR_W  burst base address to memory
read_o  output  1  memory burst read strobe
write_o  output  1  memory burst write strobe
resp_i  input  1  memory beat accepted or valid, one per beat

Behaviour:
- Reset (async assert, sync release): state IDLE; beat counter 0; line buffer 0; address_o 0; read_o, write_o, resp_o 0; burst_o 0; line_o 0.
- States: IDLE, READ, WRITE, DONE. All outputs are registered or decoded from registered state.
- IDLE: sample requests each edge.
  - write_i=1: latch line_i into buffer and address_i into address_o with low log2(LINE_W/8) bits forced to 0. Go to WRITE.
  - else read_i=1: latch the aligned address the same way. Go to READ.
  - Both high: write wins, because dirty writeback precedes the fill.
  - resp_i in IDLE is ignored.
- READ: read_o=1.
  - Each cycle with resp_i=1 writes burst_i into buffer slice [BURST_W*k +: BURST_W], where k is the beat counter, then increments k.
  - On the beat with k=BURST_LEN-1: clear k and go to DONE.
  - read_o drops in DONE.
- WRITE: write_o=1; burst_o = buffer slice k.
  - Each resp_i=1 increments k.
  - On the final beat: clear k and go to DONE.
- DONE: resp_o=1 for exactly one cycle; line_o = buffer. Always return to IDLE; requests are not sampled in DONE.
- line_o holds the last assembled line until the next read completes. A write does not alter line_o; the write uses a separate latch or the same buffer with line_o sourced from a read-only copy.
- Latency:
  - Request seen at edge 0 → read_o/write_o high from cycle 1.
  - With resp_i high every cycle from cycle 1 → final beat at cycle 4, resp_o at cycle 5, IDLE at cycle 6.
  - Memory wait states (resp_i=0) stall the counter indefinitely.
- Requests changing while in READ/WRITE/DONE are ignored. address_i and line_i need only be stable in the IDLE sampling cycle.
- Counter wraps BURST_LEN-1 → 0 only on the final beat; no over-count is possible.
- rst mid-burst: immediate return to IDLE, strobes drop asynchronously, partial line discarded. The requester must re-issue.

Optional Feature:
ADAPTOR_STATS_EN
- Defined: adds outputs rd_count_o[31:0] and wr_count_o[31:0].
  - Each increments on the DONE cycle of a completed read or write respectively.
  - Both reset to 0 on rst and wrap 0xFFFFFFFF → 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Read, no wait states: address_i=0x1234_5678, read_i=1 → address_o=0x1234_5660, read_o cycles 1-4. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → line_o={0x44..44,0x33..33,0x22..22,0x11..11}, resp_o high only at cycle 5.
- Write with waits: line_i=256'h0123..CDEF, resp_i pattern 1,0,0,1,1,0,1 → burst_o steps through slices 0..3 only on resp_i=1, write_o held 7 cycles, single resp_o pulse afterwards.
- Simultaneous request: read_i=write_i=1 in IDLE → write_o asserted, read_o stays 0 until the write completes and read_i is re-sampled.
- Reset mid-read: rst pulsed after beat 2 → read_o, resp_o 0 immediately, state IDLE. Next read assembles a fresh line with no stale beats.
- Spurious resp_i in IDLE and DONE → no counter change, no resp_o, line_o unchanged.
- With ADAPTOR_STATS_EN: 3 reads and 2 writes → rd_count_o=3, wr_count_o=2. Force counter to 0xFFFFFFFF, one read → 0.
